// File: rtl/sm_uart_bus_master.sv
// UART command port that issues single 32-bit reads/writes on the system bus
// and answers with an acknowledge byte or the read data.
module sm_uart_bus_master #(
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uartRx,
    output logic        uartTx,
    output logic        bReq,
    input  logic        bGnt,
    output logic [31:0] bAddr,
    output logic        bWrite,
    output logic [31:0] bWData,
    input  logic [31:0] bRData
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [1:0]    RW_LAST   = 2'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);
    localparam logic          RW_ZERO   = (READ_WAIT == 0);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

    // ---------------- RX ----------------
    logic            rx_s1, rx_s2, rx_s3;
    rx_state_t       rx_state, rx_state_d;
    logic [CW-1:0]   rx_cnt, rx_cnt_d;
    logic [2:0]      rx_bit, rx_bit_d;
    logic [7:0]      rx_shift, rx_shift_d;
    logic            rx_valid, rx_valid_d;
    logic            rx_ferr, rx_ferr_d;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uartRx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_valid <= rx_valid_d;
            rx_ferr  <= rx_ferr_d;
        end
    end

    // RX next state: mid-bit sampling, start-bit recheck, stop-bit validation
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + CW'(1);
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2 && rx_s3) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s2) rx_valid_d = 1'b1;
                    else       rx_ferr_d  = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- TX ----------------
    tx_state_t       tx_state, tx_state_d;
    logic [CW-1:0]   tx_cnt, tx_cnt_d;
    logic [2:0]      tx_bit, tx_bit_d;
    logic [7:0]      tx_shift, tx_shift_d;
    logic            tx_line_d;
    logic            tx_ready_c;
    logic            tx_load_c;
    logic [7:0]      tx_byte_c;

    // TX can take a new byte when idle or in the last stop-bit cycle (no gap)
    assign tx_ready_c = (tx_state == TX_IDLE) ||
                        ((tx_state == TX_STOP) && (tx_cnt == BIT_LAST));

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uartTx   <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            uartTx   <= tx_line_d;
        end
    end

    // TX next state: start, 8 data bits LSB first, stop
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CW'(1);
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_line_d  = uartTx;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load_c) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_byte_c;
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_line_d  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_load_c) begin
                        tx_state_d = TX_START;
                        tx_shift_d = tx_byte_c;
                        tx_line_d  = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // ---------------- Parser / bus ----------------
    p_state_t        p_state, p_state_d;
    logic            is_write, is_write_d;
    logic [1:0]      byte_cnt, byte_cnt_d;
    logic [31:0]     addr_sr, addr_sr_d;
    logic [31:0]     data_sr, data_sr_d;
    logic [TW-1:0]   to_cnt, to_cnt_d;
    logic            granted, granted_d;
    logic [1:0]      wcnt, wcnt_d;
    logic [31:0]     resp_sr, resp_sr_d;
    logic [2:0]      resp_left, resp_left_d;
    logic            req_d;
    logic [31:0]     addr_d, wdata_d;
    logic            read_done_c;

    // Write strobe marks the first granted cycle while the write is pending
    assign bWrite = (p_state == P_BUS) && is_write && bGnt;

    // Read data is taken READ_WAIT cycles after the grant cycle
    assign read_done_c = granted ? (wcnt == RW_LAST) : (bGnt && RW_ZERO);

    // Parser state and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state   <= P_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            to_cnt    <= '0;
            granted   <= 1'b0;
            wcnt      <= '0;
            resp_sr   <= '0;
            resp_left <= '0;
            bReq      <= 1'b0;
            bAddr     <= '0;
            bWData    <= '0;
        end else begin
            p_state   <= p_state_d;
            is_write  <= is_write_d;
            byte_cnt  <= byte_cnt_d;
            addr_sr   <= addr_sr_d;
            data_sr   <= data_sr_d;
            to_cnt    <= to_cnt_d;
            granted   <= granted_d;
            wcnt      <= wcnt_d;
            resp_sr   <= resp_sr_d;
            resp_left <= resp_left_d;
            bReq      <= req_d;
            bAddr     <= addr_d;
            bWData    <= wdata_d;
        end
    end

    // Parser next state: command decode, operand collection, bus access, response
    always_comb begin
        p_state_d   = p_state;
        is_write_d  = is_write;
        byte_cnt_d  = byte_cnt;
        addr_sr_d   = addr_sr;
        data_sr_d   = data_sr;
        to_cnt_d    = to_cnt;
        granted_d   = granted;
        wcnt_d      = wcnt;
        resp_sr_d   = resp_sr;
        resp_left_d = resp_left;
        req_d       = bReq;
        addr_d      = bAddr;
        wdata_d     = bWData;
        tx_load_c   = 1'b0;
        tx_byte_c   = resp_sr[31:24];
        case (p_state)
            P_IDLE: begin
                if (rx_valid) begin
                    if (rx_shift == CMD_WRITE || rx_shift == CMD_READ) begin
                        p_state_d  = P_ADDR;
                        is_write_d = (rx_shift == CMD_WRITE);
                        byte_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else if (tx_ready_c) begin
                        tx_load_c = 1'b1;
                        tx_byte_c = RSP_ERR;
                    end
                end
            end
            P_ADDR: begin
                if (rx_ferr) begin
                    p_state_d = P_IDLE;
                end else if (rx_valid) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt + 2'd1;
                    addr_sr_d  = {addr_sr[23:0], rx_shift};
                    if (byte_cnt == 2'd3) begin
                        if (is_write) begin
                            p_state_d = P_DATA;
                        end else begin
                            p_state_d = P_BUS;
                            req_d     = 1'b1;
                            addr_d    = {addr_sr[23:0], rx_shift};
                            granted_d = 1'b0;
                            wcnt_d    = '0;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    p_state_d = P_IDLE;
                end else begin
                    to_cnt_d = to_cnt + TW'(1);
                end
            end
            P_DATA: begin
                if (rx_ferr) begin
                    p_state_d = P_IDLE;
                end else if (rx_valid) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt + 2'd1;
                    data_sr_d  = {data_sr[23:0], rx_shift};
                    if (byte_cnt == 2'd3) begin
                        p_state_d = P_BUS;
                        req_d     = 1'b1;
                        addr_d    = addr_sr;
                        wdata_d   = {data_sr[23:0], rx_shift};
                        granted_d = 1'b0;
                    end
                end else if (to_cnt == TO_LAST) begin
                    p_state_d = P_IDLE;
                end else begin
                    to_cnt_d = to_cnt + TW'(1);
                end
            end
            P_BUS: begin
                if (is_write) begin
                    if (bGnt) begin
                        p_state_d   = P_RESP;
                        req_d       = 1'b0;
                        addr_d      = '0;
                        resp_sr_d   = {RSP_ACK, 24'h0};
                        resp_left_d = 3'd1;
                    end
                end else if (read_done_c) begin
                    p_state_d   = P_RESP;
                    req_d       = 1'b0;
                    addr_d      = '0;
                    granted_d   = 1'b0;
                    resp_sr_d   = bRData;
                    resp_left_d = 3'd4;
                end else if (granted) begin
                    wcnt_d = wcnt + 2'd1;
                end else if (bGnt) begin
                    granted_d = 1'b1;
                    wcnt_d    = '0;
                end
            end
            P_RESP: begin
                if (tx_ready_c) begin
                    if (resp_left != 3'd0) begin
                        tx_load_c   = 1'b1;
                        tx_byte_c   = resp_sr[31:24];
                        resp_sr_d   = {resp_sr[23:0], 8'h00};
                        resp_left_d = resp_left - 3'd1;
                    end else begin
                        p_state_d = P_IDLE;
                    end
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sm_uart_bus_master.sv
// Scoreboard bench for the UART bus master: expected TX bytes and bus writes are
// queued as commands are sent and compared when the DUT produces them.
module tb_sm_uart_bus_master;

    localparam int CLK_DIV   = 4;
    localparam int TIMEOUT   = 200;
    localparam int READ_WAIT = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uartRx;
    logic        uartTx;
    logic        bReq;
    logic        bGnt;
    logic [31:0] bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] tx_exp[$];
    wr_t        wr_exp[$];
    int         tx_starts[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    sm_uart_bus_master #(
        .CLK_DIV  (CLK_DIV),
        .TIMEOUT  (TIMEOUT),
        .READ_WAIT(READ_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .uartRx(uartRx),
        .uartTx(uartTx),
        .bReq  (bReq),
        .bGnt  (bGnt),
        .bAddr (bAddr),
        .bWrite(bWrite),
        .bWData(bWData),
        .bRData(bRData)
    );

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h0000_7F00) ? 32'h0000_00A5 : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign bRData = slave_data(bAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // UART TX decoder: samples mid-bit and scores each completed byte
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_shift = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (uartTx === 1'b0) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                tx_starts.push_back(cyc);
            end
        end else begin
            m_cnt++;
            if ((m_cnt % CLK_DIV) == (CLK_DIV / 2)) begin
                if ((m_cnt / CLK_DIV) >= 1 && (m_cnt / CLK_DIV) <= 8) begin
                    m_shift = {uartTx, m_shift[7:1]};
                end else if ((m_cnt / CLK_DIV) == 9) begin
                    check("tx_stop", 32'(uartTx), 32'd1);
                    if (tx_exp.size() > 0) check("tx_byte", 32'(m_shift), 32'(tx_exp.pop_front()));
                    else check("tx_extra", 32'(tx_exp.size()), 32'd1);
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Bus observer: request length, idle-address rule and write scoreboard
    int   req_len_cur = 0;
    int   last_req_len = 0;
    int   req_rises = 0;
    int   req_rise_cyc = 0;
    int   addr_viol = 0;
    int   wr_cyc = 0;
    logic prev_req = 1'b0;
    wr_t  m_wr;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_len_cur = 0;
            prev_req    = 1'b0;
        end else begin
            if (bReq && !prev_req) begin
                req_rises++;
                req_rise_cyc = cyc;
            end
            if (bReq) begin
                req_len_cur++;
            end else begin
                if (prev_req) last_req_len = req_len_cur;
                req_len_cur = 0;
                if (bAddr != 32'h0 || bWrite) addr_viol++;
            end
            if (bWrite) begin
                wr_cyc = cyc;
                if (wr_exp.size() > 0) begin
                    m_wr = wr_exp.pop_front();
                    check("wr_addr", bAddr, m_wr.addr);
                    check("wr_data", bWData, m_wr.data);
                end else begin
                    check("wr_extra", 32'(wr_exp.size()), 32'd1);
                end
            end
            prev_req = bReq;
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uartRx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uartRx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uartRx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        uartRx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) uart_send(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic expect_it);
        if (expect_it) begin
            wr_exp.push_back('{addr: a, data: d});
            tx_exp.push_back(8'h4B);
        end
        uart_send(8'h57, 1'b1);
        send_word(a);
        send_word(d);
    endtask

    task automatic do_read(input logic [31:0] a, input logic expect_it);
        logic [31:0] v;
        v = slave_data(a);
        if (expect_it) begin
            for (int i = 3; i >= 0; i--) tx_exp.push_back(v[8*i +: 8]);
        end
        uart_send(8'h52, 1'b1);
        send_word(a);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && (tx_exp.size() != 0 || m_busy); i++) @(negedge clk);
        check(tag, 32'(tx_exp.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 200 && !bReq; i++) @(negedge clk);
        check(tag, 32'(bReq), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int g;
        int bad;
        int ntx;

        rst_n  = 1'b0;
        uartRx = 1'b1;
        bGnt   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(uartTx), 32'd1);
        check("rst_req", 32'(bReq), 32'd0);
        check("rst_wr", 32'(bWrite), 32'd0);
        check("rst_addr", bAddr, 32'h0);
        check("rst_wdata", bWData, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write with grant tied high
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        drain("wr_drain_tx");
        check("wr_req_len", 32'(last_req_len), 32'd1);
        check("wr_q_empty", 32'(wr_exp.size()), 32'd0);

        // Read with back-to-back response bytes
        tx_starts.delete();
        do_read(32'h0000_7F00, 1'b1);
        drain("rd_drain_tx");
        check("rd_req_len", 32'(last_req_len), 32'(READ_WAIT + 1));
        check("rd_nbytes", 32'(tx_starts.size()), 32'd4);
        if (tx_starts.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check("rd_gap", 32'(tx_starts[i+1] - tx_starts[i]), 32'(10 * CLK_DIV));
        end

        // Grant stall during a write
        bGnt = 1'b0;
        wr_exp.push_back('{addr: 32'h1234_5678, data: 32'h0102_0304});
        tx_exp.push_back(8'h4B);
        uart_send(8'h57, 1'b1);
        send_word(32'h1234_5678);
        send_word(32'h0102_0304);
        wait_req("stall_req");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bReq || bAddr != 32'h1234_5678 || bWData != 32'h0102_0304 || bWrite) bad++;
            if (i < 9) @(negedge clk);
        end
        check("stall_stable", 32'(bad), 32'd0);
        @(posedge clk);
        #1 bGnt = 1'b1;
        g = cyc;
        drain("stall_drain_tx");
        check("stall_wr_cyc", 32'(wr_cyc), 32'(g));
        check("stall_req_len", 32'(last_req_len), 32'(g - req_rise_cyc + 1));

        // Unknown command
        rises = req_rises;
        tx_exp.push_back(8'h3F);
        uart_send(8'h41, 1'b1);
        drain("bad_cmd_tx");

        // Framing error on second address byte, then bytes land in idle
        uart_send(8'h52, 1'b1);
        uart_send(8'hA0, 1'b1);
        uart_send(8'hA1, 1'b0);
        repeat (10) @(negedge clk);
        tx_exp.push_back(8'h3F);
        uart_send(8'hA2, 1'b1);
        drain("ferr_tx1");
        tx_exp.push_back(8'h3F);
        uart_send(8'hA3, 1'b1);
        drain("ferr_tx2");
        check("ferr_no_req", 32'(req_rises), 32'(rises));

        // Inter-byte timeout, then a full read
        uart_send(8'h52, 1'b1);
        uart_send(8'h00, 1'b1);
        repeat (TIMEOUT + 20) @(negedge clk);
        check("to_no_req", 32'(req_rises), 32'(rises));
        do_read(32'h0000_0040, 1'b1);
        drain("to_read_tx");
        check("to_read_req", 32'(req_rises), 32'(rises + 1));

        // Reset during TX bit 3 of a read response
        do_read(32'h0000_7F00, 1'b0);
        for (int i = 0; i < 400 && uartTx; i++) @(negedge clk);
        repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
        check("pre_rst_line", 32'(uartTx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_line", 32'(uartTx), 32'd1);
        check("rst_tx_req", 32'(bReq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset during a stalled request
        bGnt = 1'b0;
        do_write(32'hCAFE_0000, 32'h1122_3344, 1'b0);
        wait_req("rst_bus_pre");
        rst_n = 1'b0;
        #1;
        check("rst_bus_req", 32'(bReq), 32'd0);
        check("rst_bus_addr", bAddr, 32'h0);
        check("rst_bus_wr", 32'(bWrite), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bGnt  = 1'b1;
        repeat (5) @(negedge clk);
        do_write(32'h0000_0020, 32'h55AA_55AA, 1'b1);
        drain("post_rst_tx");
        check("post_rst_wq", 32'(wr_exp.size()), 32'd0);

        // Short low glitch must not start a frame
        ntx = tx_starts.size();
        @(negedge clk);
        uartRx = 1'b0;
        @(negedge clk);
        uartRx = 1'b1;
        repeat (20 * CLK_DIV) @(negedge clk);
        check("glitch_no_tx", 32'(tx_starts.size()), 32'(ntx));
        do_read(32'h0000_1234, 1'b1);
        drain("glitch_read_tx");

        check("idle_addr_zero", 32'(addr_viol), 32'd0);
        check("end_wr_q", 32'(wr_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
